// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling
// ratios and the parity convention common to transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int OS_8  = 8;
    localparam int OS_16 = 16;
    localparam int OS_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic os_legal(input int os);
        return (os == OS_8) || (os == OS_16) || (os == OS_32);
    endfunction

    // Parity bit that makes the frame's total one-count even (typ=0) or odd (typ=1).
    function automatic logic parity_bit(input logic [7:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Three-point majority sampler: captures the line at H-1 and H, and votes
// with the live sample at H+1, when decide_o strobes.
module rx_bit_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic [$clog2(OVERSAMPLE)-1:0] edge_cnt_i,
    output logic                          bit_o,
    output logic                          decide_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int H  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] POS_A   = CW'(H - 1);
    localparam logic [CW-1:0] POS_B   = CW'(H);
    localparam logic [CW-1:0] POS_DEC = CW'(H + 1);

    logic s0_q, s1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (edge_cnt_i == POS_A) s0_q <= rx_i;
            if (edge_cnt_i == POS_B) s1_q <= rx_i;
        end
    end

    assign bit_o    = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
    assign decide_o = (edge_cnt_i == POS_DEC);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 frames with optional even/odd parity,
// byte output with a one-cycle valid strobe and per-frame error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       PAR_ERR,
    output logic       STP_ERR,
    output logic       busy,
    output rx_state_e  dbg_state_o
);
    // Handshake: Data_Valid/PAR_ERR/STP_ERR are single-cycle pulses with no
    // back-pressure; P_DATA is only meaningful (and only changes) with Data_Valid.
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] EDGE_LAST = CW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q, p_data_q;
    logic          par_en_q, par_typ_q, par_fail_q;
    logic          armed_q, fin_q, fin_stop_q;
    logic          valid_q, par_err_q, stp_err_q, busy_q;
    logic          bit_wrap, smp_bit, smp_decide;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s     = sync_q[1];
    assign bit_wrap = (edge_cnt_q == EDGE_LAST);

    always_comb begin
        edge_cnt_d = bit_wrap ? '0 : edge_cnt_q + CW'(1);
    end

    rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rx_i       (rx_s),
        .edge_cnt_i (edge_cnt_q),
        .bit_o      (smp_bit),
        .decide_o   (smp_decide)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            armed_q    <= 1'b1;
            fin_q      <= 1'b0;
            fin_stop_q <= 1'b1;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            busy_q    <= (state_q != ST_IDLE);

            // Frame verdict is published one cycle after the stop decision so
            // the FSM is already free to catch a back-to-back start bit.
            if (fin_q) begin
                fin_q <= 1'b0;
                if (fin_stop_q && !par_fail_q) begin
                    p_data_q <= shift_q;
                    valid_q  <= 1'b1;
                end else begin
                    par_err_q <= par_fail_q;
                    stp_err_q <= !fin_stop_q;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (!armed_q) begin
                        if (rx_s) armed_q <= 1'b1;
                    end else if (!rx_s) begin
                        state_q    <= ST_START;
                        edge_cnt_q <= CW'(1);
                        bit_cnt_q  <= '0;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_fail_q <= 1'b0;
                    end
                end
                ST_START: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (smp_decide && smp_bit) begin
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= '0;
                    end else if (bit_wrap) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (smp_decide) shift_q[bit_cnt_q] <= smp_bit;
                    if (bit_wrap) begin
                        if (bit_cnt_q == 3'd7) state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        else                   bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (smp_decide) par_fail_q <= (smp_bit != parity_bit(shift_q, par_typ_q));
                    if (bit_wrap) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (smp_decide) begin
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= '0;
                        fin_q      <= 1'b1;
                        fin_stop_q <= smp_bit;
                        // A low stop bit disarms IDLE so a stuck-low line reports once.
                        armed_q    <= smp_bit;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    edge_cnt_q <= '0;
                end
            endcase
        end
    end

    assign P_DATA      = p_data_q;
    assign Data_Valid  = valid_q;
    assign PAR_ERR     = par_err_q;
    assign STP_ERR     = stp_err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
